// File: rtl/tmds_pkg.sv
// Shared TMDS definitions: control tokens, their {C1,C0} decode and the aligner state set.
package tmds_pkg;

  localparam logic [9:0] TOKEN_C00 = 10'h354;
  localparam logic [9:0] TOKEN_C01 = 10'h0AB;
  localparam logic [9:0] TOKEN_C10 = 10'h154;
  localparam logic [9:0] TOKEN_C11 = 10'h2AB;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    SETTLE = 2'd1,
    LOCKED = 2'd2
  } alignState_e;

  typedef struct packed {
    logic       isCtrl;
    logic [1:0] code;
  } tokenInfo_t;

  function automatic tokenInfo_t decodeToken(input logic [9:0] word);
    tokenInfo_t info;
    info = '{isCtrl: 1'b0, code: 2'b00};
    case (word)
      TOKEN_C00: info = '{isCtrl: 1'b1, code: 2'b00};
      TOKEN_C01: info = '{isCtrl: 1'b1, code: 2'b01};
      TOKEN_C10: info = '{isCtrl: 1'b1, code: 2'b10};
      TOKEN_C11: info = '{isCtrl: 1'b1, code: 2'b11};
      default:   info = '{isCtrl: 1'b0, code: 2'b00};
    endcase
    return info;
  endfunction

endpackage

// File: rtl/tmds_gearbox_5to10.sv
// Collects 5-bit nibbles into a 20-bit history and picks a 10-bit word at the requested bit slip.
module tmds_gearbox_5to10
  import tmds_pkg::*;
(
  input  logic       clkLoad,
  input  logic       reset,
  input  logic       nibbleStrobe,
  input  logic [4:0] nibbleData,
  input  logic [3:0] slip,
  output logic [9:0] rawWord,
  output logic       rawStrobe
);

  logic [19:0] history;
  logic [19:0] historyNext;
  logic        phase;

  // Oldest bit sits at history[0]; new nibbles enter at the top.
  assign historyNext = {nibbleData, history[19:5]};

  always_ff @(posedge clkLoad or posedge reset) begin
    if (reset) begin
      history <= '0;
      phase   <= 1'b0;
    end else if (nibbleStrobe) begin
      history <= historyNext;
      phase   <= ~phase;
    end
  end

  assign rawStrobe = nibbleStrobe & phase;

  always_comb begin
    rawWord = '0;
    for (int i = 0; i < 10; i++) begin
      if (slip == i[3:0]) rawWord = historyNext[i +: 10];
    end
  end

endmodule

// File: rtl/tmds_rx_word_aligner.sv
// Regroups nibbles into TMDS words, hunts the bit offset on runs of control tokens and
// flags control-period words once locked.
//
//  state  | meaning
//  SEARCH | counting tokens at the current slip; slips after a full idle window
//  SETTLE | history refilling after a slip; words are suppressed
//  LOCKED | alignment held; drops back to SEARCH after a full idle window
module tmds_rx_word_aligner
  import tmds_pkg::*;
#(
  parameter int CTRL_RUN     = 8,
  parameter int WINDOW_WORDS = 8192,
  parameter int SETTLE_WORDS = 4
) (
  input  logic       clkLoad,
  input  logic       reset,
  input  logic       nibbleStrobe,
  input  logic [4:0] nibbleData,
  input  logic       resync,
  output logic       wordStrobe,
  output logic [9:0] wordData,
  output logic       isControl,
  output logic [1:0] controlBits,
  output logic       locked,
  output logic [3:0] slipOffset
);

  localparam int               CNT_W        = $clog2(WINDOW_WORDS + 1);
  localparam logic [CNT_W-1:0] RUN_MAX      = CNT_W'(CTRL_RUN);
  localparam logic [CNT_W-1:0] IDLE_LIMIT   = CNT_W'(WINDOW_WORDS - 1);
  localparam logic [CNT_W-1:0] SETTLE_LIMIT = CNT_W'(SETTLE_WORDS);

  alignState_e      state, stateNext;
  logic [CNT_W-1:0] runCnt, runNext, runInc;
  logic [CNT_W-1:0] idleCnt, idleNext, idleInc, settleInc;
  logic [3:0]       slip, slipNext;
  logic [9:0]       rawWord;
  logic             rawStrobe;
  logic             runHit;
  tokenInfo_t       token;

  tmds_gearbox_5to10 gearbox (
    .clkLoad      (clkLoad),
    .reset        (reset),
    .nibbleStrobe (nibbleStrobe),
    .nibbleData   (nibbleData),
    .slip         (slip),
    .rawWord      (rawWord),
    .rawStrobe    (rawStrobe)
  );

  assign token      = decodeToken(rawWord);
  assign slipOffset = slip;

  always_comb begin
    stateNext = state;
    runNext   = runCnt;
    idleNext  = idleCnt;
    slipNext  = slip;

    if (token.isCtrl) runInc = (runCnt == RUN_MAX) ? RUN_MAX : runCnt + 1'b1;
    else              runInc = '0;
    runHit    = (runInc == RUN_MAX);
    // A saturated run keeps re-arming the idle window on every further token.
    idleInc   = runHit ? '0 : idleCnt + 1'b1;
    settleInc = idleCnt + 1'b1;

    if (rawStrobe) begin
      case (state)
        SEARCH: begin
          runNext  = runInc;
          idleNext = idleInc;
          if (runHit) begin
            stateNext = LOCKED;
          end else if (idleInc == IDLE_LIMIT) begin
            slipNext  = (slip == 4'd9) ? 4'd0 : slip + 4'd1;
            runNext   = '0;
            idleNext  = '0;
            stateNext = SETTLE;
          end
        end
        SETTLE: begin
          idleNext = settleInc;
          if (settleInc == SETTLE_LIMIT) begin
            runNext   = '0;
            idleNext  = '0;
            stateNext = SEARCH;
          end
        end
        LOCKED: begin
          runNext  = runInc;
          idleNext = idleInc;
          if (idleInc == IDLE_LIMIT) begin
            runNext   = '0;
            idleNext  = '0;
            stateNext = SEARCH;
          end
        end
        default: stateNext = SEARCH;
      endcase
    end

    if (resync) begin
      stateNext = SEARCH;
      runNext   = '0;
      idleNext  = '0;
    end
  end

  always_ff @(posedge clkLoad or posedge reset) begin
    if (reset) begin
      state       <= SEARCH;
      runCnt      <= '0;
      idleCnt     <= '0;
      slip        <= '0;
      locked      <= 1'b0;
      wordStrobe  <= 1'b0;
      wordData    <= '0;
      isControl   <= 1'b0;
      controlBits <= '0;
    end else begin
      state      <= stateNext;
      runCnt     <= runNext;
      idleCnt    <= idleNext;
      slip       <= slipNext;
      locked     <= (stateNext == LOCKED);
      wordStrobe <= rawStrobe && (state != SETTLE);
      if (rawStrobe && (state != SETTLE)) begin
        wordData    <= rawWord;
        isControl   <= token.isCtrl;
        controlBits <= token.code;
      end
    end
  end

endmodule

// File: tb/tb_tmds_rx_word_aligner.sv
// Directed bench for the TMDS word aligner: slip search, lock, idle drop, resync, strobe gaps, reset.
module tb_tmds_rx_word_aligner;

  logic       clkLoad = 1'b0;
  logic       reset;
  logic       nibbleStrobe;
  logic [4:0] nibbleData;
  logic       resync;
  logic       wordStrobe;
  logic [9:0] wordData;
  logic       isControl;
  logic [1:0] controlBits;
  logic       locked;
  logic [3:0] slipOffset;

  int         checks   = 0;
  int         failures = 0;
  logic [2:0] carry;

  always #5 clkLoad = ~clkLoad;

  tmds_rx_word_aligner #(
    .CTRL_RUN     (8),
    .WINDOW_WORDS (256),
    .SETTLE_WORDS (4)
  ) dut (
    .clkLoad      (clkLoad),
    .reset        (reset),
    .nibbleStrobe (nibbleStrobe),
    .nibbleData   (nibbleData),
    .resync       (resync),
    .wordStrobe   (wordStrobe),
    .wordData     (wordData),
    .isControl    (isControl),
    .controlBits  (controlBits),
    .locked       (locked),
    .slipOffset   (slipOffset)
  );

  task automatic tick;
    @(posedge clkLoad);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic sendNibble(input logic [4:0] n, input logic r);
    nibbleStrobe = 1'b1;
    nibbleData   = n;
    resync       = r;
    tick;
    nibbleStrobe = 1'b0;
    nibbleData   = '0;
    resync       = 1'b0;
  endtask

  task automatic sendPair(input logic [9:0] p, input logic r);
    sendNibble(p[4:0], 1'b0);
    sendNibble(p[9:5], r);
  endtask

  // Stream delayed by 3 bits, so the true word boundary sits at slip 3.
  task automatic sendWord(input logic [9:0] w, input logic r);
    logic [12:0] c;
    c     = {w, carry};
    carry = c[12:10];
    sendPair(c[9:0], r);
  endtask

  task automatic sendWordGap(input logic [9:0] w, input logic [9:0] expPrev);
    logic [12:0] c;
    c     = {w, carry};
    carry = c[12:10];
    sendNibble(c[4:0], 1'b0);
    chk("gap_nib1_no_strobe", wordStrobe, 1'b0);
    tick;
    chk("gap_idle1_no_strobe", wordStrobe, 1'b0);
    sendNibble(c[9:5], 1'b0);
    chk("gap_strobe", wordStrobe, 1'b1);
    chk("gap_word", wordData, expPrev);
    tick;
    chk("gap_idle2_no_strobe", wordStrobe, 1'b0);
  endtask

  initial begin
    int         strobes, tok, dataCnt, gapCnt, at1, at2, at3;
    logic [3:0] lastSlip;

    reset        = 1'b1;
    nibbleStrobe = 1'b0;
    nibbleData   = '0;
    resync       = 1'b0;
    carry        = '0;
    repeat (3) tick;
    chk("rst_strobe", wordStrobe, 1'b0);
    chk("rst_locked", locked, 1'b0);
    chk("rst_slip", slipOffset, 4'd0);
    chk("rst_data", wordData, 10'h000);
    reset = 1'b0;
    tick;

    // Skewed data-only stream: slips every 255 strobed words plus 4 silent settle words
    strobes  = 0;
    at1      = -1;
    at2      = -1;
    at3      = -1;
    lastSlip = '0;
    for (int i = 0; i < 1200 && slipOffset != 4'd3; i++) begin
      sendWord(i[0] ? 10'h01F : 10'h3E0, 1'b0);
      if (wordStrobe) strobes++;
      if (slipOffset != lastSlip) begin
        if (slipOffset == 4'd1)      at1 = strobes;
        else if (slipOffset == 4'd2) at2 = strobes;
        else if (slipOffset == 4'd3) at3 = strobes;
        lastSlip = slipOffset;
      end
    end
    chk("slip1_at_strobe", at1, 255);
    chk("slip2_at_strobe", at2, 510);
    chk("slip3_at_strobe", at3, 765);
    chk("search_unlocked", locked, 1'b0);

    gapCnt = 0;
    for (int i = 0; i < 10; i++) begin
      sendWord(i[0] ? 10'h01F : 10'h3E0, 1'b0);
      if (wordStrobe) break;
      gapCnt++;
    end
    chk("settle_silent_words", gapCnt, 4);

    tok = 0;
    for (int i = 0; i < 12 && tok < 8; i++) begin
      sendWord(10'h354, 1'b0);
      if (wordStrobe && isControl) tok++;
      if (tok == 7) chk("lock_not_early", locked, 1'b0);
    end
    chk("lock_token_count", tok, 8);
    chk("locked_on_8th", locked, 1'b1);
    chk("lock_slip3", slipOffset, 4'd3);
    chk("lock_word", wordData, 10'h354);
    chk("lock_ctrlbits_00", controlBits, 2'b00);

    sendWord(10'h0AB, 1'b0);
    sendWord(10'h154, 1'b0);
    chk("tok0AB_word", wordData, 10'h0AB);
    chk("tok0AB_isctrl", isControl, 1'b1);
    chk("tok0AB_bits", controlBits, 2'b01);
    sendWord(10'h2AB, 1'b0);
    chk("tok154_bits", controlBits, 2'b10);
    sendWord(10'h354, 1'b0);
    chk("tok2AB_bits", controlBits, 2'b11);

    // Idle timeout while locked
    dataCnt = 0;
    for (int i = 0; i < 300 && dataCnt < 255; i++) begin
      sendWord(i[0] ? 10'h01F : 10'h3E0, 1'b0);
      if (wordStrobe && !isControl) begin
        dataCnt++;
        if (dataCnt == 254) chk("still_locked_254", locked, 1'b1);
      end
    end
    chk("idle_data_count", dataCnt, 255);
    chk("unlocked_on_255", locked, 1'b0);
    chk("slip_kept", slipOffset, 4'd3);
    chk("data_ctrlbits_zero", controlBits, 2'b00);

    // Resync on the 8th token
    tok = 0;
    for (int i = 0; i < 8; i++) begin
      sendWord(10'h354, 1'b0);
      if (wordStrobe && isControl) tok++;
    end
    chk("pre_resync_tokens", tok, 7);
    chk("pre_resync_unlocked", locked, 1'b0);
    sendWord(10'h354, 1'b1);
    chk("resync_word_token", isControl, 1'b1);
    chk("resync_blocks_lock", locked, 1'b0);
    tok = 0;
    for (int i = 0; i < 8; i++) begin
      sendWord(10'h354, 1'b0);
      if (wordStrobe && isControl) tok++;
      if (tok == 7) chk("relock_not_early", locked, 1'b0);
    end
    chk("relock_token_count", tok, 8);
    chk("relocked", locked, 1'b1);

    // Gap-free then alternate-cycle strobes
    sendWord(10'h2C3, 1'b0);
    sendWord(10'h11D, 1'b0);
    chk("nogap_word", wordData, 10'h2C3);
    chk("nogap_isctrl", isControl, 1'b0);
    chk("nogap_bits", controlBits, 2'b00);
    tick;
    chk("nogap_pulse", wordStrobe, 1'b0);
    sendWordGap(10'h0F0, 10'h11D);
    sendWordGap(10'h1A5, 10'h0F0);
    sendWordGap(10'h3C7, 10'h1A5);
    chk("gap_still_locked", locked, 1'b1);

    // Asynchronous reset mid-stream
    #2 reset = 1'b1;
    #1;
    chk("midrst_locked", locked, 1'b0);
    chk("midrst_slip", slipOffset, 4'd0);
    chk("midrst_word", wordData, 10'h000);
    chk("midrst_strobe", wordStrobe, 1'b0);
    tick;
    tick;
    reset = 1'b0;
    carry = '0;
    tick;
    chk("postrst_slip", slipOffset, 4'd0);
    chk("postrst_locked", locked, 1'b0);

    // Aligned 0x354 stream at slip 0
    sendNibble(5'h14, 1'b0);
    chk("t2_nib1_no_strobe", wordStrobe, 1'b0);
    sendNibble(5'h1A, 1'b0);
    chk("t2_strobe_after_nib2", wordStrobe, 1'b1);
    chk("t2_first_word", wordData, 10'h000);
    tick;
    chk("t2_strobe_pulse", wordStrobe, 1'b0);
    tok = 0;
    for (int i = 0; i < 10 && tok < 8; i++) begin
      sendPair(10'h354, 1'b0);
      if (wordStrobe && isControl) tok++;
      if (tok == 7) chk("t2_not_early", locked, 1'b0);
    end
    chk("t2_token_count", tok, 8);
    chk("t2_locked", locked, 1'b1);
    chk("t2_bits", controlBits, 2'b00);
    chk("t2_slip0", slipOffset, 4'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
